// File: rtl/dvs_ravens_pkg.sv
// Shared types and constants for the DVS camera front end.
package dvs_ravens_pkg;

    // Width of one address-event word from the camera.
    localparam int unsigned EVENT_BITS = 16;

    // AER receiver handshake states.
    typedef enum logic [1:0] {
        IDLE,
        PUSH,
        ACK
    } aer_rx_state_t;

endpackage

// File: rtl/dvs_sync_ff.sv
// N-stage single-bit synchroniser, asynchronous active-high reset to 0.
module dvs_sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sync_q;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d};
        end
    end

    assign q = sync_q[STAGES-1];

endmodule

// File: rtl/dvs_aer_event_receiver.sv
// Terminates the camera's 4-phase AER handshake and pushes one word per event into the queue.
module dvs_aer_event_receiver
    import dvs_ravens_pkg::*;
#(
    parameter bit          DROP_ON_FULL  = 1'b0,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter int unsigned DROP_CNT_BITS = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     aer_req,
    input  logic [EVENT_BITS-1:0]    aer_data,
    output logic                     aer_ack,
    input  logic                     fifo_full,
    output logic                     fifo_wr_en,
    output logic [EVENT_BITS-1:0]    fifo_event_in,
    output logic [DROP_CNT_BITS-1:0] drop_count,
    output logic                     busy
);

    logic                     req_s;
    aer_rx_state_t            state_q, state_d;
    logic [EVENT_BITS-1:0]    event_q, event_d;
    logic [DROP_CNT_BITS-1:0] drop_q, drop_d;
    logic                     ack_q, ack_d;

    // aer_req is only ever observed through this synchroniser.
    dvs_sync_ff #(
        .STAGES (SYNC_STAGES)
    ) u_req_sync (
        .clk (clk),
        .rst (rst),
        .d   (aer_req),
        .q   (req_s)
    );

    // Next-state, event capture and drop counting.
    always_comb begin
        state_d = state_q;
        event_d = event_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: begin
                // aer_data is sampled only here; it is held stable by the camera until ack.
                if (req_s) begin
                    event_d = aer_data;
                    state_d = PUSH;
                end
            end
            PUSH: begin
                if (!fifo_full) begin
                    state_d = ACK;
                end else if (DROP_ON_FULL) begin
                    if (drop_q != '1) begin
                        drop_d = drop_q + 1'b1;
                    end
                    state_d = ACK;
                end
            end
            ACK: begin
                if (!req_s) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        // Registered ack: set on entry to ACK, cleared on the edge that leaves it.
        ack_d = (state_d == ACK);
    end

    // State, captured event, drop counter and ack registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            event_q <= '0;
            drop_q  <= '0;
            ack_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            event_q <= event_d;
            drop_q  <= drop_d;
            ack_q   <= ack_d;
        end
    end

    // PUSH lasts one cycle unless stalled by a full queue, so pushes never occur back to back.
    assign fifo_wr_en    = (state_q == PUSH) && !fifo_full;
    assign fifo_event_in = event_q;
    assign aer_ack       = ack_q;
    assign drop_count    = drop_q;
    assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_dvs_aer_event_receiver.sv
// Self-checking bench: stall-mode receiver (default parameters) and a drop-mode receiver.
module tb_dvs_aer_event_receiver;
    import dvs_ravens_pkg::*;

    localparam int EB = EVENT_BITS;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Stall-mode DUT
    logic          aer_req, aer_ack, fifo_full, fifo_wr_en, busy;
    logic [EB-1:0] aer_data, fifo_event_in;
    logic [15:0]   drop_count;

    // Drop-mode DUT
    logic          d_req, d_ack, d_full, d_wr, d_busy;
    logic [EB-1:0] d_data, d_evt;
    logic [1:0]    d_cnt;

    dvs_aer_event_receiver u_dut (
        .clk           (clk),
        .rst           (rst),
        .aer_req       (aer_req),
        .aer_data      (aer_data),
        .aer_ack       (aer_ack),
        .fifo_full     (fifo_full),
        .fifo_wr_en    (fifo_wr_en),
        .fifo_event_in (fifo_event_in),
        .drop_count    (drop_count),
        .busy          (busy)
    );

    dvs_aer_event_receiver #(
        .DROP_ON_FULL  (1'b1),
        .SYNC_STAGES   (2),
        .DROP_CNT_BITS (2)
    ) u_dut_drop (
        .clk           (clk),
        .rst           (rst),
        .aer_req       (d_req),
        .aer_data      (d_data),
        .aer_ack       (d_ack),
        .fifo_full     (d_full),
        .fifo_wr_en    (d_wr),
        .fifo_event_in (d_evt),
        .drop_count    (d_cnt),
        .busy          (d_busy)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Behavioural queue: records every word the receiver pushes.
    logic [EB-1:0] pushed[$];
    int push_cnt   = 0;
    int d_push_cnt = 0;
    int consec     = 0;
    logic last_wr  = 1'b0;

    always @(posedge clk) begin
        if (fifo_wr_en === 1'b1) begin
            pushed.push_back(fifo_event_in);
            push_cnt <= push_cnt + 1;
            if (last_wr) consec <= consec + 1;
        end
        last_wr <= (fifo_wr_en === 1'b1);
        if (d_wr === 1'b1) d_push_cnt <= d_push_cnt + 1;
    end

    task automatic pop_check(input string name, input logic [EB-1:0] exp);
        logic [EB-1:0] w;
        w = '1;
        if (pushed.size() != 0) w = pushed.pop_front();
        else w = ~exp;
        check(name, w, exp);
    endtask

    // Full 4-phase handshake on the stall DUT; fifo_full held for full_cycles cycles.
    // aer_data is corrupted right after capture to prove the word is isolated.
    task automatic hs(input logic [EB-1:0] d, input int full_cycles);
        int  n;
        int  viol;
        bit  changed;
        n = 0; viol = 0; changed = 0;
        @(negedge clk);
        aer_data  = d;
        aer_req   = 1'b1;
        fifo_full = (full_cycles > 0);
        while (aer_ack !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
            if (busy && !changed) begin
                aer_data = ~d;
                changed  = 1;
            end
            if (fifo_full) begin
                if (fifo_wr_en !== 1'b0 || aer_ack !== 1'b0) viol++;
                if (n >= full_cycles) fifo_full = 1'b0;
            end
        end
        fifo_full = 1'b0;
        check("stall_quiet", viol, 0);
        check("ack_rise", aer_ack, 1);
        aer_req = 1'b0;
        n = 0;
        while (aer_ack !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("ack_fall", aer_ack, 0);
    endtask

    // Handshake on the drop DUT; returns whether ack was seen.
    task automatic dhs(input logic [EB-1:0] d, output bit got_ack);
        int n;
        n = 0;
        @(negedge clk);
        d_data = d;
        d_req  = 1'b1;
        while (d_ack !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        got_ack = (d_ack === 1'b1);
        d_req = 1'b0;
        n = 0;
        while (d_ack !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("d_ack_fall", d_ack, 0);
    endtask

    typedef struct {
        logic [EB-1:0] data;
        int            full_cycles;
        logic [EB-1:0] exp_word;
        int            exp_pushes;
    } vec_t;

    vec_t tbl[10];
    logic [EB-1:0] exp_q[$];

    initial begin
        int  base;
        int  n;
        int  acks;
        bit  got;
        logic [EB-1:0] r;

        tbl[0] = '{16'h0001, 0, 16'h0001, 1};
        tbl[1] = '{16'h0002, 0, 16'h0002, 1};
        tbl[2] = '{16'h0003, 0, 16'h0003, 1};
        tbl[3] = '{16'h0004, 0, 16'h0004, 1};
        tbl[4] = '{16'h0005, 0, 16'h0005, 1};
        tbl[5] = '{16'h0006, 0, 16'h0006, 1};
        tbl[6] = '{16'h0007, 0, 16'h0007, 1};
        tbl[7] = '{16'h0008, 0, 16'h0008, 1};
        tbl[8] = '{16'h02A5, 20, 16'h02A5, 1};
        tbl[9] = '{16'hBEEF, 3, 16'hBEEF, 1};

        rst = 1'b1;
        aer_req = 1'b0; aer_data = '0; fifo_full = 1'b0;
        d_req = 1'b0; d_data = '0; d_full = 1'b1;
        repeat (3) @(negedge clk);

        // Reset state
        check("rst_ack", aer_ack, 0);
        check("rst_wr", fifo_wr_en, 0);
        check("rst_evt", fifo_event_in, 0);
        check("rst_drop", drop_count, 0);
        check("rst_busy", busy, 0);
        check("rst_d_cnt", d_cnt, 0);
        rst = 1'b0;
        @(negedge clk);

        // Latency of a single event: req rises before edge k
        aer_data = 16'h02A5;
        aer_req  = 1'b1;
        @(negedge clk);                                  // after k
        check("lat_k_wr", fifo_wr_en, 0);
        @(negedge clk);                                  // after k+1
        check("lat_k1_wr", fifo_wr_en, 0);
        check("lat_k1_busy", busy, 0);
        @(negedge clk);                                  // after k+2
        check("lat_k2_wr", fifo_wr_en, 1);
        check("lat_k2_evt", fifo_event_in, 16'h02A5);
        check("lat_k2_ack", aer_ack, 0);
        @(negedge clk);                                  // after k+3
        check("lat_k3_wr", fifo_wr_en, 0);
        check("lat_k3_ack", aer_ack, 1);
        aer_req = 1'b0;                                  // falls before edge m
        @(negedge clk);
        check("lat_m_ack", aer_ack, 1);
        @(negedge clk);
        check("lat_m1_ack", aer_ack, 1);
        @(negedge clk);
        check("lat_m2_ack", aer_ack, 0);
        check("lat_m2_busy", busy, 0);
        check("lat_pushes", push_cnt, 1);
        pop_check("lat_word", 16'h02A5);

        // Table: back-to-back events and stalls
        for (int i = 0; i < 10; i++) begin
            base = push_cnt;
            hs(tbl[i].data, tbl[i].full_cycles);
            check("tbl_pushes", push_cnt - base, tbl[i].exp_pushes);
            pop_check("tbl_word", tbl[i].exp_word);
        end
        check("stall_drop_cnt", drop_count, 0);

        // Reset while stalled in PUSH with req held high
        @(negedge clk);
        fifo_full = 1'b1;
        aer_data  = 16'h00C3;
        aer_req   = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        base = push_cnt;
        rst = 1'b1;
        #1;
        check("rstp_ack", aer_ack, 0);
        check("rstp_wr", fifo_wr_en, 0);
        check("rstp_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        fifo_full = 1'b0;
        n = 0;
        while (aer_ack !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("rstp_reack", aer_ack, 1);
        check("rstp_pushes", push_cnt - base, 1);
        pop_check("rstp_word", 16'h00C3);
        // Reset while in ACK: ack must drop at once
        rst = 1'b1;
        #1;
        check("rsta_ack", aer_ack, 0);
        aer_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        check("rsta_idle", busy, 0);

        // Protocol violation: req drops while stalled in PUSH
        base = push_cnt;
        fifo_full = 1'b1;
        aer_data  = 16'h1234;
        aer_req   = 1'b1;
        n = 0;
        while (busy !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        aer_req = 1'b0;
        repeat (3) @(negedge clk);
        check("viol_ack_low", aer_ack, 0);
        fifo_full = 1'b0;
        @(negedge clk);
        check("viol_ack", aer_ack, 1);
        @(negedge clk);
        check("viol_ack_fall", aer_ack, 0);
        check("viol_pushes", push_cnt - base, 1);
        pop_check("viol_word", 16'h1234);

        // Randomised traffic against a plain expected-order queue
        base = push_cnt;
        for (int i = 0; i < 30; i++) begin
            r = EB'($urandom);
            exp_q.push_back(r);
            hs(r, int'($urandom_range(0, 6)));
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end
        check("rand_pushes", push_cnt - base, exp_q.size());
        n = 0;
        while (exp_q.size() != 0 && pushed.size() != 0) begin
            if (pushed.pop_front() !== exp_q.pop_front()) n++;
        end
        check("rand_words", n, 0);
        check("rand_leftover", pushed.size() + exp_q.size(), 0);
        check("no_consec_wr", consec, 0);

        // Drop mode: queue always full, counter saturates at 3
        acks = 0;
        for (int i = 0; i < 5; i++) begin
            dhs(EB'(i + 16'h0100), got);
            if (got) acks++;
            check("drop_cnt", d_cnt, (i + 1 > 3) ? 3 : i + 1);
        end
        check("drop_acks", acks, 5);
        check("drop_pushes", d_push_cnt, 0);
        d_full = 1'b0;
        dhs(16'h0777, got);
        check("drop_free_ack", got, 1);
        check("drop_free_push", d_push_cnt, 1);
        check("drop_free_evt", d_evt, 16'h0777);
        check("drop_free_cnt", d_cnt, 3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
